// File: rtl/bignum_operand_bank.sv
// ---------------------------------------------------------------------------
// bignum_operand_bank
//
// Holds the two multi-word operands (A and B) of the RSA datapath. It answers
// the comparator's read interface and is loaded through a streaming write
// port, least-significant word first.
//
// Ports
//   CLK, RST_N        clock (posedge) and asynchronous active-low reset
//   clear_start       pulse: zero both banks, one word per cycle
//   clear_done        one-cycle pulse once the last word has been cleared
//   wr_valid/wr_ready write handshake; a word is taken when both are high
//   wr_sel            0 = operand A, 1 = operand B (sampled on the first word)
//   wr_data, wr_last  write word and end-of-operand marker
//   load_done         one-cycle pulse after the last word is taken
//   overflow          sticky: a word past DEPTH-1 was dropped
//   top_index_a/b     index of the highest nonzero word of the last load
//   busy              high whenever the bank is not idle
//   data_r_en         read request
//   data_addr         read word index (full 32-bit range check)
//   read_data1/2      registered words of operand A / operand B
// ---------------------------------------------------------------------------
module bignum_operand_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  clear_start,
  output logic                  clear_done,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  wr_sel,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  output logic                  load_done,
  output logic                  overflow,
  output logic [31:0]           top_index_a,
  output logic [31:0]           top_index_b,
  output logic                  busy,
  input  logic                  data_r_en,
  input  logic [31:0]           data_addr,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;

  // One extra bit so the write pointer can sit at DEPTH once the bank is full.
  localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [1:0]            state;
  logic [AW:0]           waddr;
  logic [AW-1:0]         caddr;
  logic                  sel_q;

  logic [DATA_WIDTH-1:0] bank_a [DEPTH];
  logic [DATA_WIDTH-1:0] bank_b [DEPTH];

  logic                  take;
  logic                  in_range;
  logic                  we_a;
  logic                  we_b;
  logic [AW-1:0]         widx;
  logic [DATA_WIDTH-1:0] wdata;

  logic                  rd_in_range;
  logic [AW-1:0]         rd_idx;
  logic [DATA_WIDTH-1:0] rd_a_p1;
  logic [DATA_WIDTH-1:0] rd_b_p1;

  assign wr_ready = (state != S_CLEAR);
  assign busy     = (state != S_IDLE);

  // A clear request in IDLE pre-empts a word offered in the same cycle, so
  // that word is not taken even though wr_ready is high.
  assign take     = wr_valid && wr_ready && !((state == S_IDLE) && clear_start);
  assign in_range = (waddr < DEPTH_W);

  assign rd_in_range = (data_addr < 32'(DEPTH));
  assign rd_idx      = data_addr[AW-1:0];

  assign read_data1 = rd_a_p1;
  assign read_data2 = rd_b_p1;

  // Single write port shared by the loader and the clear engine.
  always_comb begin
    we_a  = 1'b0;
    we_b  = 1'b0;
    widx  = '0;
    wdata = '0;
    case (state)
      S_IDLE: begin
        if (take) begin
          wdata = wr_data;
          we_a  = !wr_sel;
          we_b  = wr_sel;
        end
      end
      S_LOAD: begin
        if (take && in_range) begin
          widx  = waddr[AW-1:0];
          wdata = wr_data;
          we_a  = !sel_q;
          we_b  = sel_q;
        end
      end
      S_CLEAR: begin
        widx = caddr;
        we_a = 1'b1;
        we_b = 1'b1;
      end
      default: ;
    endcase
  end

  // Bank storage: no reset, contents are only defined after a clear.
  always_ff @(posedge CLK) begin
    if (we_a) bank_a[widx] <= wdata;
  end

  always_ff @(posedge CLK) begin
    if (we_b) bank_b[widx] <= wdata;
  end

  // Control state machine.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      waddr       <= '0;
      caddr       <= '0;
      sel_q       <= 1'b0;
      load_done   <= 1'b0;
      clear_done  <= 1'b0;
      overflow    <= 1'b0;
      top_index_a <= '0;
      top_index_b <= '0;
    end else begin
      load_done  <= 1'b0;
      clear_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (clear_start) begin
            state <= S_CLEAR;
            caddr <= '0;
          end else if (take) begin
            // First word always lands at index 0, so the top index restarts at 0.
            sel_q    <= wr_sel;
            overflow <= 1'b0;
            if (wr_sel) top_index_b <= '0;
            else        top_index_a <= '0;
            if (wr_last) begin
              load_done <= 1'b1;
              waddr     <= '0;
            end else begin
              state <= S_LOAD;
              waddr <= (AW + 1)'(1);
            end
          end
        end
        S_LOAD: begin
          if (take) begin
            if (in_range) begin
              // Indices only grow within a load, so the latest nonzero wins.
              if (|wr_data) begin
                if (sel_q) top_index_b <= 32'(waddr);
                else       top_index_a <= 32'(waddr);
              end
              waddr <= waddr + 1'b1;
            end else begin
              overflow <= 1'b1;
            end
            if (wr_last) begin
              load_done <= 1'b1;
              state     <= S_IDLE;
              waddr     <= '0;
            end
          end
        end
        S_CLEAR: begin
          caddr <= caddr + 1'b1;
          if (caddr == LAST_ADDR) begin
            clear_done  <= 1'b1;
            top_index_a <= '0;
            top_index_b <= '0;
            caddr       <= '0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---- stage p1: registered read, old word returned on a same-index write ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_a_p1 <= '0;
      rd_b_p1 <= '0;
    end else if (data_r_en) begin
      if (rd_in_range) begin
        rd_a_p1 <= bank_a[rd_idx];
        rd_b_p1 <= bank_b[rd_idx];
      end else begin
        rd_a_p1 <= '0;
        rd_b_p1 <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bignum_operand_bank.sv
module tb_bignum_operand_bank;

  localparam int DW    = 32;
  localparam int DEPTH = 64;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b1;
  logic          clear_start = 1'b0;
  logic          clear_done;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic          wr_sel = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_last = 1'b0;
  logic          load_done;
  logic          overflow;
  logic [31:0]   top_index_a;
  logic [31:0]   top_index_b;
  logic          busy;
  logic          data_r_en = 1'b0;
  logic [31:0]   data_addr = '0;
  logic [DW-1:0] read_data1;
  logic [DW-1:0] read_data2;

  bignum_operand_bank #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .clear_start(clear_start), .clear_done(clear_done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel),
    .wr_data(wr_data), .wr_last(wr_last), .load_done(load_done),
    .overflow(overflow), .top_index_a(top_index_a), .top_index_b(top_index_b),
    .busy(busy), .data_r_en(data_r_en), .data_addr(data_addr),
    .read_data1(read_data1), .read_data2(read_data2)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // reference model of the banks and status
  logic [DW-1:0] ma [DEPTH];
  logic [DW-1:0] mb [DEPTH];
  logic [DW-1:0] lw [80];
  logic          m_ovf = 1'b0;
  logic [31:0]   m_top_a = '0;
  logic [31:0]   m_top_b = '0;
  logic [DW-1:0] hold1 = '0;
  logic [DW-1:0] hold2 = '0;

  typedef struct {
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    string         nm;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0]   addr;
    logic          en;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } vec_t;
  vec_t vt [9];

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // drive one read, queue its expectation, compare one cycle later
  task automatic rd_push(input logic [31:0] addr, input logic en,
                         input logic [DW-1:0] e1, input logic [DW-1:0] e2, input string nm);
    exp_t e;
    data_r_en = en;
    data_addr = addr;
    sb.push_back('{d1: e1, d2: e2, nm: nm});
    step();
    e = sb.pop_front();
    chk({e.nm, "_d1"}, 64'(read_data1), 64'(e.d1));
    chk({e.nm, "_d2"}, 64'(read_data2), 64'(e.d2));
    data_r_en = 1'b0;
  endtask

  task automatic model_rd(input logic [31:0] addr, input string nm);
    if (addr < DEPTH) begin
      hold1 = ma[addr];
      hold2 = mb[addr];
    end else begin
      hold1 = '0;
      hold2 = '0;
    end
    rd_push(addr, 1'b1, hold1, hold2, nm);
  endtask

  // stream lw[0..n-1] into operand sel; wr_sel is inverted after word 0 and must be ignored
  task automatic load(input logic sel, input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_sel   = (i == 0) ? sel : ~sel;
      wr_data  = lw[i];
      wr_last  = (i == n - 1);
      if (i == 0) begin
        m_ovf = 1'b0;
        if (sel) m_top_b = '0; else m_top_a = '0;
      end
      if (i < DEPTH) begin
        if (sel) mb[i] = lw[i]; else ma[i] = lw[i];
        if (lw[i] != '0) begin
          if (sel) m_top_b = i; else m_top_a = i;
        end
      end else begin
        m_ovf = 1'b1;
      end
      step();
      if (i == n - 2) chk({nm, "_no_early_done"}, 64'(load_done), 64'd0);
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    chk({nm, "_load_done"}, 64'(load_done), 64'd1);
    chk({nm, "_overflow"}, 64'(overflow), 64'(m_ovf));
    chk({nm, "_top_a"}, 64'(top_index_a), 64'(m_top_a));
    chk({nm, "_top_b"}, 64'(top_index_b), 64'(m_top_b));
    step();
    chk({nm, "_done_pulse"}, 64'(load_done), 64'd0);
    chk({nm, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic do_clear(input logic with_wr, input logic restart_mid, input string nm);
    int  cnt;
    logic done;
    clear_start = 1'b1;
    wr_valid    = with_wr;
    wr_sel      = 1'b0;
    wr_data     = 32'hAA;
    wr_last     = 1'b1;
    step();
    clear_start = 1'b0;
    wr_valid    = 1'b0;
    wr_last     = 1'b0;
    chk({nm, "_busy"}, 64'(busy), 64'd1);
    chk({nm, "_ready_low"}, 64'(wr_ready), 64'd0);
    chk({nm, "_no_load_done"}, 64'(load_done), 64'd0);
    cnt  = 0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      clear_start = (restart_mid && i == 10);
      step();
      cnt++;
      if (clear_done) done = 1'b1;
    end
    clear_start = 1'b0;
    chk({nm, "_timeout"}, 64'(done), 64'd1);
    chk({nm, "_cycles"}, 64'(cnt), 64'(DEPTH));
    chk({nm, "_top_a0"}, 64'(top_index_a), 64'd0);
    chk({nm, "_top_b0"}, 64'(top_index_b), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
    m_top_a = '0;
    m_top_b = '0;
    step();
    chk({nm, "_done_pulse"}, 64'(clear_done), 64'd0);
    chk({nm, "_idle"}, 64'(busy), 64'd0);
    chk({nm, "_ready"}, 64'(wr_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    vt[0] = '{addr: 32'd2,          en: 1'b1, e1: 32'd5, e2: 32'd4};
    vt[1] = '{addr: 32'd128,        en: 1'b1, e1: 32'd0, e2: 32'd0};
    vt[2] = '{addr: 32'd5,          en: 1'b0, e1: 32'd0, e2: 32'd0};
    vt[3] = '{addr: 32'd0,          en: 1'b1, e1: 32'd1, e2: 32'd1};
    vt[4] = '{addr: 32'd7,          en: 1'b0, e1: 32'd1, e2: 32'd1};
    vt[5] = '{addr: 32'd2,          en: 1'b1, e1: 32'd5, e2: 32'd4};
    vt[6] = '{addr: 32'h1000_0002,  en: 1'b1, e1: 32'd0, e2: 32'd0};
    vt[7] = '{addr: 32'd2,          en: 1'b1, e1: 32'd5, e2: 32'd4};
    vt[8] = '{addr: 32'd64,         en: 1'b1, e1: 32'd0, e2: 32'd0};

    // reset values
    #2 RST_N = 1'b0;
    step();
    step();
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_load_done", 64'(load_done), 64'd0);
    chk("rst_clear_done", 64'(clear_done), 64'd0);
    chk("rst_top_a", 64'(top_index_a), 64'd0);
    chk("rst_top_b", 64'(top_index_b), 64'd0);
    chk("rst_rd1", 64'(read_data1), 64'd0);
    chk("rst_rd2", 64'(read_data2), 64'd0);
    RST_N = 1'b1;
    step();

    // clear and scan
    do_clear(1'b0, 1'b0, "clr1");
    for (int i = 0; i < DEPTH; i++) model_rd(i, "scan0");

    // small operands
    lw[0] = 32'd1; lw[1] = 32'd0; lw[2] = 32'd5;
    load(1'b0, 3, "loadA");
    lw[0] = 32'd1; lw[1] = 32'd0; lw[2] = 32'd4;
    load(1'b1, 3, "loadB");

    // read table: range check, hold behaviour, high address bits
    for (int i = 0; i < 9; i++) begin
      rd_push(vt[i].addr, vt[i].en, vt[i].e1, vt[i].e2, $sformatf("vec%0d", i));
      hold1 = vt[i].e1;
      hold2 = vt[i].e2;
    end

    // read-before-write on the same index
    wr_valid = 1'b1; wr_sel = 1'b0; wr_data = 32'd9; wr_last = 1'b1;
    data_r_en = 1'b1; data_addr = 32'd0;
    sb.push_back('{d1: ma[0], d2: mb[0], nm: "rbw"});
    step();
    e = sb.pop_front();
    chk({e.nm, "_d1"}, 64'(read_data1), 64'(e.d1));
    chk({e.nm, "_d2"}, 64'(read_data2), 64'(e.d2));
    chk("rbw_load_done", 64'(load_done), 64'd1);
    chk("rbw_top_a", 64'(top_index_a), 64'd0);
    wr_valid = 1'b0; wr_last = 1'b0; data_r_en = 1'b0;
    ma[0] = 32'd9; m_top_a = '0;
    step();
    model_rd(0, "rbw_new");

    // overflow: 66 words into A
    for (int i = 0; i < 66; i++) lw[i] = 32'(i + 10);
    load(1'b0, 66, "ovf");
    chk("ovf_top63", 64'(top_index_a), 64'd63);
    for (int i = 0; i < DEPTH; i++) model_rd(i, "scan_ovf");
    chk("ovf_sticky", 64'(overflow), 64'd1);
    lw[0] = 32'd7;
    load(1'b1, 1, "after_ovf");
    chk("ovf_cleared", 64'(overflow), 64'd0);
    model_rd(0, "after_ovf_rd");

    // trailing zero words leave top index unchanged
    lw[0] = 32'd3; lw[1] = 32'd9; lw[2] = 32'd0; lw[3] = 32'd0;
    load(1'b0, 4, "zeros");
    chk("zeros_top1", 64'(top_index_a), 64'd1);

    // clear wins over same-cycle write; restart during clear ignored
    do_clear(1'b1, 1'b1, "clr2");
    model_rd(0, "clr2_rd0");
    model_rd(40, "clr2_rd40");

    // reset in the middle of a load
    wr_valid = 1'b1; wr_sel = 1'b0; wr_data = 32'd5; wr_last = 1'b0;
    step();
    chk("mid_busy", 64'(busy), 64'd1);
    wr_data = 32'd6; data_r_en = 1'b1; data_addr = 32'd0;
    step();
    chk("mid_rd1", 64'(read_data1), 64'd5);
    wr_valid = 1'b0; data_r_en = 1'b0;
    RST_N = 1'b0;
    #1;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_ready", 64'(wr_ready), 64'd1);
    chk("mrst_rd1", 64'(read_data1), 64'd0);
    chk("mrst_rd2", 64'(read_data2), 64'd0);
    chk("mrst_load_done", 64'(load_done), 64'd0);
    step();
    RST_N = 1'b1;
    step();
    chk("mrst_no_done", 64'(load_done), 64'd0);
    chk("mrst_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
